hazard_control_unit: RTL and testbench
======================================

Name: hazard_control_unit

Overview:
- Pipeline scheduler for the 5-stage core. Takes the decode-stage fields (opcode, rs1, rs2, rd) and the EX-stage branch resolution.
- Keeps its own shadow record of in-flight writers in EX/MEM/WB.
- Drives PC and IF/ID write enables, the IF/ID flush and the ID/EX bubble. Provides hazard statistics counters.
- Sits beside the decode stage; sequences the fetch/decode datapath.

Parameters:
- CNT_WIDTH, 32, width of the stall and flush statistic counters (wrap on overflow).

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- id_valid  input  1  ID stage holds a real instruction
- id_opcode  input  7  opcode of the ID instruction
- id_rs1  input  5  source register 1 of the ID instruction
- id_rs2  input  5  source register 2 of the ID instruction
- id_rd  input  5  destination register of the ID instruction
- ex_branch_taken  input  1  EX resolved a taken branch/JAL/JALR this cycle
- pc_write_en  output  1  PC may update
- if_id_write_en  output  1  IF/ID register may load
- if_id_flush  output  1  IF/ID register loads a NOP
- id_ex_bubble  output  1  ID/EX register loads a NOP
- stall_count  output  CNT_WIDTH  cycles lost to data-hazard stalls
- flush_count  output  CNT_WIDTH  taken-branch flush events
- fwd_a_sel  output  2  rs1 operand source for the instruction now in EX (FORWARD_EN only)
- fwd_b_sel  output  2  rs2 operand source for the instruction now in EX (FORWARD_EN only)

Behaviour:
- Opcode classes:
  - Uses rs1: 0110011, 0010011, 0000011, 0100011, 1100011, 1100111.
  - Uses rs2: 0110011, 0100011, 1100011.
  - Writes rd: 0110011, 0010011, 0000011, 0110111, 0010111, 1101111, 1100111.
  - Load: 0000011.
  - Any other opcode: no reads, no writes.
- Shadow pipeline: three slots EX, MEM, WB; each holds {valid, rd, is_load}.
  - A slot counts as a writer only if valid, writes rd, and rd != 0.
  - Each cycle: WB<=MEM, MEM<=EX.
  - EX<=ID entry when id_valid and id_ex_bubble=0; otherwise EX<=invalid.
- Register file is write-before-read: a writer in the WB slot never causes a hazard.
- hazard = id_valid and the ID instruction uses a register equal to a writer's rd in a hazard slot; rs == 0 never matches. Hazard slots depend on FORWARD_EN (see Optional Feature).
- Output rules, priority order:
  1. ex_branch_taken=1: pc_write_en=1, if_id_write_en=1, if_id_flush=1, id_ex_bubble=1. Any concurrent hazard is ignored because the ID instruction is squashed. flush_count+1.
  2. hazard=1: pc_write_en=0, if_id_write_en=0, if_id_flush=0, id_ex_bubble=1. stall_count+1 per cycle.
  3. Otherwise: pc_write_en=1, if_id_write_en=1, if_id_flush=0, id_ex_bubble=0.
- Control outputs are combinational from the shadow state and current inputs. Counters and fwd selects are registered.
- Stall length:
  - Hazard holds until the producer reaches WB.
  - Maximum 2 consecutive cycles without FORWARD_EN; exactly 1 with it (load-use only).
  - A taken branch arriving mid-stall ends the stall that cycle.
- id_valid=0: no hazard ever; normal advance; the bubble enters EX.
- Reset asserted, immediately and asynchronously:
  - All shadow slots invalid; counters 0; fwd selects 00.
  - pc_write_en=0, if_id_write_en=0, if_id_flush=0, id_ex_bubble=1.
  - First cycle after release: normal advance.
- Counters wrap from all-ones to 0.

Optional Feature:
- Macro FORWARD_EN.
- Undefined:
  - Hazard slots are EX and MEM (RAW against either stalls).
  - fwd_a_sel and fwd_b_sel are tied to 00.
- Defined:
  - Hazard only against an EX-slot writer with is_load=1 (load-use).
  - fwd selects are registered when an instruction enters EX; set to 00 when a bubble enters.
  - Per operand, computed from the ID instruction:
    - 01 (take EX/MEM result) if it matches the EX-slot writer.
    - Else 10 (take MEM/WB result) if it matches the MEM-slot writer.
    - Else 00 (register file).
    - The EX match has priority.

Test Plan:
- Reset, then id_valid=0 for 3 cycles -> pc_write_en=1, id_ex_bubble=0, stall_count=0.
- add x5 (rd=5, 0110011) then sub using rs1=5; no FORWARD_EN -> 2 stall cycles (pc_write_en=0, id_ex_bubble=1), stall_count=2.
- Same sequence with FORWARD_EN -> no stall; sub enters EX with fwd_a_sel=01. Independent instruction between them -> fwd_a_sel=10.
- lw x7 then add rs2=7 with FORWARD_EN -> exactly 1 stall cycle; add enters EX with fwd_b_sel=10; stall_count=1.
- Hazard active while ex_branch_taken=1 -> if_id_flush=1, id_ex_bubble=1, pc_write_en=1; flush_count=1; stall_count unchanged.
- Writer with rd=0 followed by consumer of rs1=0 -> no stall. Reset asserted mid-stall -> outputs take reset values that same cycle; no stall after release.

Source files
------------

// File: rtl/hazard_control_unit_if.sv
// Decode-side bundle between the ID stage and the hazard scheduler.
// Carries decode fields, branch resolution, control strobes and statistics.
interface hazard_control_unit_if #(
    parameter int CNT_WIDTH = 32
);
    logic                 id_valid;
    logic [6:0]           id_opcode;
    logic [4:0]           id_rs1;
    logic [4:0]           id_rs2;
    logic [4:0]           id_rd;
    logic                 ex_branch_taken;
    logic                 pc_write_en;
    logic                 if_id_write_en;
    logic                 if_id_flush;
    logic                 id_ex_bubble;
    logic [CNT_WIDTH-1:0] stall_count;
    logic [CNT_WIDTH-1:0] flush_count;
    logic [1:0]           fwd_a_sel;
    logic [1:0]           fwd_b_sel;

    modport master (
        output id_valid, id_opcode, id_rs1, id_rs2, id_rd, ex_branch_taken,
        input  pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble,
        input  stall_count, flush_count, fwd_a_sel, fwd_b_sel
    );

    modport slave (
        input  id_valid, id_opcode, id_rs1, id_rs2, id_rd, ex_branch_taken,
        output pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble,
        output stall_count, flush_count, fwd_a_sel, fwd_b_sel
    );
endinterface

// File: rtl/hazard_control_unit.sv
// Stall/flush scheduler for the 5-stage core, tracking in-flight writers.
// Define FORWARD_EN for forwarding selects and load-use-only stalls.
module hazard_control_unit #(
    parameter int CNT_WIDTH = 32
) (
    input logic                  clk,
    input logic                  reset,
    hazard_control_unit_if.slave hif
);
    function automatic logic uses_rs1(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0010011, 7'b0000011,
                          7'b0100011, 7'b1100011, 7'b1100111};
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0100011, 7'b1100011};
    endfunction

    function automatic logic writes_rd(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0110111,
                          7'b0010111, 7'b1101111, 7'b1100111};
    endfunction

    // WB writers never hazard (write-before-read), so only EX/MEM are kept.
    logic                 ex_w, mem_w;
    logic [4:0]           ex_rd, mem_rd;
    logic [CNT_WIDTH-1:0] stall_cnt, flush_cnt;

    logic rd1, rd2, wr, enter, hazard;
    logic a_ex, a_mem, b_ex, b_mem;
    logic pc_we, ifid_we, flush, bubble;

    assign rd1 = hif.id_valid && uses_rs1(hif.id_opcode) && (hif.id_rs1 != 5'd0);
    assign rd2 = hif.id_valid && uses_rs2(hif.id_opcode) && (hif.id_rs2 != 5'd0);
    assign wr  = writes_rd(hif.id_opcode) && (hif.id_rd != 5'd0);

    assign a_ex  = rd1 && ex_w  && (ex_rd  == hif.id_rs1);
    assign a_mem = rd1 && mem_w && (mem_rd == hif.id_rs1);
    assign b_ex  = rd2 && ex_w  && (ex_rd  == hif.id_rs2);
    assign b_mem = rd2 && mem_w && (mem_rd == hif.id_rs2);

    assign enter = hif.id_valid && !bubble;

`ifdef FORWARD_EN
    logic       ex_ld;
    logic [1:0] fa, fb;

    assign hazard = ex_ld && (a_ex || b_ex);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_ld <= 1'b0;
            fa    <= 2'b00;
            fb    <= 2'b00;
        end else begin
            ex_ld <= enter && wr && (hif.id_opcode == 7'b0000011);
            fa    <= !enter ? 2'b00 : a_ex ? 2'b01 : a_mem ? 2'b10 : 2'b00;
            fb    <= !enter ? 2'b00 : b_ex ? 2'b01 : b_mem ? 2'b10 : 2'b00;
        end
    end

    assign hif.fwd_a_sel = fa;
    assign hif.fwd_b_sel = fb;
`else
    assign hazard = a_ex || a_mem || b_ex || b_mem;

    assign hif.fwd_a_sel = 2'b00;
    assign hif.fwd_b_sel = 2'b00;
`endif

    always_comb begin
        pc_we   = 1'b1;
        ifid_we = 1'b1;
        flush   = 1'b0;
        bubble  = 1'b0;
        if (reset) begin
            pc_we   = 1'b0;
            ifid_we = 1'b0;
            bubble  = 1'b1;
        end else if (hif.ex_branch_taken) begin
            flush  = 1'b1;
            bubble = 1'b1;
        end else if (hazard) begin
            pc_we   = 1'b0;
            ifid_we = 1'b0;
            bubble  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_w      <= 1'b0;
            ex_rd     <= 5'd0;
            mem_w     <= 1'b0;
            mem_rd    <= 5'd0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            mem_w  <= ex_w;
            mem_rd <= ex_rd;
            ex_w   <= enter && wr;
            ex_rd  <= hif.id_rd;
            if (hif.ex_branch_taken)
                flush_cnt <= flush_cnt + CNT_WIDTH'(1);
            else if (hazard)
                stall_cnt <= stall_cnt + CNT_WIDTH'(1);
        end
    end

    assign hif.pc_write_en    = pc_we;
    assign hif.if_id_write_en = ifid_we;
    assign hif.if_id_flush    = flush;
    assign hif.id_ex_bubble   = bubble;
    assign hif.stall_count    = stall_cnt;
    assign hif.flush_count    = flush_cnt;
endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed scoreboard bench for hazard_control_unit.
// Expectations follow FORWARD_EN when the macro is defined.
module tb_hazard_control_unit;
    localparam logic [6:0] R   = 7'b0110011;
    localparam logic [6:0] I   = 7'b0010011;
    localparam logic [6:0] LD  = 7'b0000011;
    localparam logic [3:0] NORM  = 4'b1100;
    localparam logic [3:0] STALL = 4'b0001;
    localparam logic [3:0] FLUSH = 4'b1111;
    localparam logic [3:0] RST   = 4'b0001;

    typedef struct {
        logic [3:0] ctl;
        logic [1:0] fa;
        logic [1:0] fb;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;
    int   exp_stall = 0;
    int   exp_flush = 0;
    exp_t exp_q[$];

    hazard_control_unit_if #(.CNT_WIDTH(32)) hif();

    hazard_control_unit #(.CNT_WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .hif   (hif.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] ctl_obs();
        return {hif.pc_write_en, hif.if_id_write_en,
                hif.if_id_flush, hif.id_ex_bubble};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic v, input logic [6:0] op,
                         input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] rd, input logic br);
        hif.id_valid        = v;
        hif.id_opcode       = op;
        hif.id_rs1          = r1;
        hif.id_rs2          = r2;
        hif.id_rd           = rd;
        hif.ex_branch_taken = br;
    endtask

    task automatic step(input logic v, input logic [6:0] op,
                        input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] rd, input logic br,
                        input logic [3:0] ctl, input logic [1:0] fa,
                        input logic [1:0] fb);
        exp_t e;
        @(negedge clk);
        drive(v, op, r1, r2, rd, br);
        exp_q.push_back('{ctl: ctl, fa: fa, fb: fb});
        #1;
        e = exp_q.pop_front();
        chk("ctl", 32'(ctl_obs()), 32'(e.ctl));
        if (e.ctl == FLUSH) exp_flush++;
        else if (e.ctl == STALL) exp_stall++;
        @(posedge clk);
        #1;
        chk("stall_count", hif.stall_count, exp_stall);
        chk("flush_count", hif.flush_count, exp_flush);
        chk("fwd_a_sel", 32'(hif.fwd_a_sel), 32'(e.fa));
        chk("fwd_b_sel", 32'(hif.fwd_b_sel), 32'(e.fb));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, NORM, 2'b00, 2'b00);
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
        #1;
        chk("reset_ctl", 32'(ctl_obs()), 32'(RST));
        chk("reset_stall", hif.stall_count, 0);
        chk("reset_flush", hif.flush_count, 0);
        chk("reset_fwd", 32'({hif.fwd_a_sel, hif.fwd_b_sel}), 0);
        @(negedge clk);
        reset = 1'b0;

        idle(3);

        // add x5 then sub rs1=5
        step(1, R, 5'd1, 5'd2, 5'd5, 0, NORM, 2'b00, 2'b00);
`ifdef FORWARD_EN
        step(1, R, 5'd5, 5'd6, 5'd8, 0, NORM, 2'b01, 2'b00);
`else
        step(1, R, 5'd5, 5'd6, 5'd8, 0, STALL, 2'b00, 2'b00);
        step(1, R, 5'd5, 5'd6, 5'd8, 0, STALL, 2'b00, 2'b00);
        step(1, R, 5'd5, 5'd6, 5'd8, 0, NORM, 2'b00, 2'b00);
`endif
        idle(3);

        // independent addi between producer and consumer
        step(1, R, 5'd1, 5'd2, 5'd5, 0, NORM, 2'b00, 2'b00);
        step(1, I, 5'd3, 5'd0, 5'd9, 0, NORM, 2'b00, 2'b00);
`ifdef FORWARD_EN
        step(1, R, 5'd5, 5'd6, 5'd8, 0, NORM, 2'b10, 2'b00);
`else
        step(1, R, 5'd5, 5'd6, 5'd8, 0, STALL, 2'b00, 2'b00);
        step(1, R, 5'd5, 5'd6, 5'd8, 0, NORM, 2'b00, 2'b00);
`endif
        idle(3);

        // lw x7 then add rs2=7
        step(1, LD, 5'd1, 5'd0, 5'd7, 0, NORM, 2'b00, 2'b00);
`ifdef FORWARD_EN
        step(1, R, 5'd3, 5'd7, 5'd10, 0, STALL, 2'b00, 2'b00);
        step(1, R, 5'd3, 5'd7, 5'd10, 0, NORM, 2'b00, 2'b10);
`else
        step(1, R, 5'd3, 5'd7, 5'd10, 0, STALL, 2'b00, 2'b00);
        step(1, R, 5'd3, 5'd7, 5'd10, 0, STALL, 2'b00, 2'b00);
        step(1, R, 5'd3, 5'd7, 5'd10, 0, NORM, 2'b00, 2'b00);
`endif
        idle(3);

        // load-use hazard squashed by a taken branch
        step(1, LD, 5'd1, 5'd0, 5'd5, 0, NORM, 2'b00, 2'b00);
        step(1, R, 5'd5, 5'd2, 5'd11, 1, FLUSH, 2'b00, 2'b00);
        idle(3);

        // writer to x0 never creates a dependency
        step(1, LD, 5'd1, 5'd0, 5'd0, 0, NORM, 2'b00, 2'b00);
        step(1, R, 5'd0, 5'd0, 5'd12, 0, NORM, 2'b00, 2'b00);
        idle(3);

        // reset asserted in the middle of a stall cycle
        step(1, LD, 5'd1, 5'd0, 5'd7, 0, NORM, 2'b00, 2'b00);
        @(negedge clk);
        drive(1, R, 5'd3, 5'd7, 5'd10, 0);
        #1;
        chk("midstall_ctl", 32'(ctl_obs()), 32'(STALL));
        #1;
        reset = 1'b1;
        #1;
        exp_stall = 0;
        exp_flush = 0;
        chk("async_rst_ctl", 32'(ctl_obs()), 32'(RST));
        chk("async_rst_stall", hif.stall_count, exp_stall);
        chk("async_rst_flush", hif.flush_count, exp_flush);
        @(negedge clk);
        reset = 1'b0;
        step(1, R, 5'd3, 5'd7, 5'd10, 0, NORM, 2'b00, 2'b00);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
